nibble_serial_adder: RTL

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_pkg.sv | 21 ++
 rtl/ripple_carry_adder_4_bit.sv | 38 +++
 rtl/nibble_serial_adder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_pkg
//
// Shared definitions for the nibble-serial adder slice.
//   NIBBLE_W : width of the reused adder slice (one nibble).
//   state_t  : controller states.
//              IDLE = waiting for a request.
//              RUN  = stepping through the nibbles.
//              DONE = holding the result until the consumer takes it.
// -----------------------------------------------------------------------------
package nibble_serial_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : nibble_serial_pkg

// File: rtl/ripple_carry_adder_4_bit.sv
// -----------------------------------------------------------------------------
// ripple_carry_adder_4_bit
//
// Purely combinational 4-bit ripple-carry adder. The nibble-serial adder
// reuses this slice once per nibble.
//
// Ports
//   a, b  : in,  NIBBLE_W bits, addends
//   cin   : in,  1 bit, carry into bit 0
//   s     : out, NIBBLE_W bits, sum
//   cout  : out, 1 bit, carry out of the top bit
// -----------------------------------------------------------------------------
module ripple_carry_adder_4_bit
    import nibble_serial_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    // The carry is a procedural variable rather than a carry vector, so each
    // stage reads the value left by the previous stage. This keeps the ripple
    // explicit without a vector whose bits depend on its own other bits.
    logic c;

    always_comb begin
        c = cin;
        s = '0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule : ripple_carry_adder_4_bit

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Adds two WIDTH-bit operands one nibble per cycle, least-significant nibble
// first. A single 4-bit ripple-carry adder is reused for every nibble. The
// result is produced NIB = WIDTH/4 cycles after the request is accepted.
//
// Optional feature
//   NIBBLE_SERIAL_ADDER_SUB_EN : when defined, adds the input `sub`. With
//   sub=1 the block computes a - b (mod 2^WIDTH) by adding the inverse of b
//   with an initial carry of 1. In that mode carry_out=1 means no borrow.
//   When it is undefined, the port is absent and the block always adds.
//
// Parameters
//   WIDTH     : operand/result width. Must be a multiple of 4 and >= 8.
//
// Ports
//   clk       : in,  1 bit, rising-edge clock
//   rst_n     : in,  1 bit, asynchronous active-low reset
//   in_valid  : in,  1 bit, request operands valid
//   in_ready  : out, 1 bit, block can accept a request (IDLE only)
//   a, b      : in,  WIDTH bits, operands
//   carry_in  : in,  1 bit, initial carry
//   sub       : in,  1 bit, subtract select (only with the macro)
//   out_valid : out, 1 bit, result valid (DONE only)
//   out_ready : in,  1 bit, consumer accepts the result
//   sum       : out, WIDTH bits, result
//   carry_out : out, 1 bit, carry out of bit WIDTH-1
//
// Handshake
//   A transfer happens on a rising edge where valid and ready are both 1.
//   A producer holding valid must keep its data stable until that edge.
//   The request side accepts only in IDLE, which latches a, b, carry_in (and
//   sub). The result side presents only in DONE, where sum and carry_out stay
//   frozen until out_ready is seen. Because in_ready is 0 in DONE, a request
//   is never accepted on the edge that consumes a result. There is always at
//   least one IDLE cycle between back-to-back requests.
// -----------------------------------------------------------------------------
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Controller state
    // -------------------------------------------------------------------------
    state_t state;
    state_t state_nxt;

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;        // already inverted when subtracting
    logic             carry_q;    // carry between nibble steps
    logic [IDX_W-1:0] idx;        // nibble currently being added
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             accept;
    logic             consume;
    logic             last_nib;

    // -------------------------------------------------------------------------
    // Operand conditioning at capture time. Subtraction is folded into the
    // captured copy of b and the initial carry. The running datapath then
    // never needs to know which operation it is doing.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    always_comb begin
        b_eff   = sub ? ~b : b;
        cin_eff = sub ? 1'b1 : carry_in;
    end
`else
    always_comb begin
        b_eff   = b;
        cin_eff = carry_in;
    end
`endif

    // -------------------------------------------------------------------------
    // Nibble select into the shared adder
    // -------------------------------------------------------------------------
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] add_s;
    logic                add_c;

    always_comb begin
        a_nib = a_q[int'(idx) * NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[int'(idx) * NIBBLE_W +: NIBBLE_W];
    end

    ripple_carry_adder_4_bit u_rca (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_c)
    );

    // -------------------------------------------------------------------------
    // Handshake qualifiers
    // -------------------------------------------------------------------------
    assign accept   = in_valid  && in_ready;
    assign consume  = out_ready && out_valid;
    assign last_nib = (idx == IDX_LAST);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = RUN;
            RUN:     if (last_nib) state_nxt = DONE;
            DONE:    if (consume)  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (Moore, decoded from state only)
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath sequencing
    // -------------------------------------------------------------------------
    // sum and carry_out are cleared when a new request is accepted. This means
    // nothing from an earlier operation can leak into the nibbles that are not
    // yet written. Inputs are only sampled on the accepting edge, so later
    // input activity cannot disturb a running operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= a;
                        b_q     <= b_eff;
                        carry_q <= cin_eff;
                        idx     <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_q[int'(idx) * NIBBLE_W +: NIBBLE_W] <= add_s;
                    carry_q <= add_c;
                    if (last_nib) begin
                        idx    <= '0;
                        cout_q <= add_c;
                    end else begin
                        idx    <= idx + 1'b1;
                    end
                end
                default: ;  // DONE holds the result
            endcase
        end
    end

    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule : nibble_serial_adder
